// File: rtl/fixed_power_if.sv
// fixed_power_if: request/result handshake between a requester (master) and fixed_power (slave).
interface fixed_power_if #(
    parameter int DATA_W = 20,
    parameter int EXP_W  = 3
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data_1;
    logic [EXP_W-1:0]  in_data_2;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (output in_valid, in_data_1, in_data_2, input out_valid, out_data);
    modport slave  (input in_valid, in_data_1, in_data_2, output out_valid, out_data);
endinterface

// File: rtl/fixed_power.sv
// fixed_power: unsigned Q10.10 x^n by repeated truncating multiply, one multiply per cycle.
// Define FIXED_POWER_SAT_EN to saturate the result to all-ones when any multiply overflows.
module fixed_power #(
    parameter int DATA_W = 20,
    parameter int FRAC_W = 10,
    parameter int EXP_W  = 3
) (
    input logic          clk,
    input logic          rst_n,
    fixed_power_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_W;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   acc, acc_nxt, x_reg, x_nxt, out_data, out_data_nxt, result;
    logic [EXP_W-1:0]    rem, rem_nxt;
    logic                ovf, ovf_nxt, out_valid, out_valid_nxt;
    logic [2*DATA_W-1:0] p;
    logic                unused_bits;

    assign p = acc * x_reg;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;

`ifdef FIXED_POWER_SAT_EN
    assign result      = ovf ? '1 : acc;
    assign unused_bits = ^p[FRAC_W-1:0];
`else
    assign result      = acc;
    assign unused_bits = ^{ovf, p[FRAC_W-1:0]};
`endif

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        x_nxt         = x_reg;
        rem_nxt       = rem;
        ovf_nxt       = ovf;
        out_valid_nxt = 1'b0;
        out_data_nxt  = out_data;
        case (state)
            IDLE: if (bus.in_valid) begin
                x_nxt     = bus.in_data_1;
                acc_nxt   = (bus.in_data_2 == '0) ? ONE : bus.in_data_1;
                rem_nxt   = bus.in_data_2 - 1'b1;
                ovf_nxt   = 1'b0;
                state_nxt = (bus.in_data_2 <= EXP_W'(1)) ? DONE : MULT;
            end
            MULT: begin
                // product is shifted back to Q10.10; anything above DATA_W is overflow
                acc_nxt   = p[DATA_W+FRAC_W-1:FRAC_W];
                ovf_nxt   = ovf | (|p[2*DATA_W-1:DATA_W+FRAC_W]);
                rem_nxt   = rem - 1'b1;
                state_nxt = (rem == EXP_W'(1)) ? DONE : MULT;
            end
            DONE: begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = result;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            x_reg     <= '0;
            rem       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            x_reg     <= x_nxt;
            rem       <= rem_nxt;
            ovf       <= ovf_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
        end
    end
endmodule

// File: tb/tb_fixed_power.sv
// tb_fixed_power: scoreboard bench for fixed_power; expected values and arrival cycles are queued at issue.
module tb_fixed_power;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        logic [19:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    fixed_power_if #(.DATA_W(20), .EXP_W(3)) bus ();

    fixed_power #(.DATA_W(20), .FRAC_W(10), .EXP_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [19:0] pow_ref(input logic [19:0] x, input int n);
        longint unsigned a;
        bit ovf;
        ovf = 0;
        a = (n == 0) ? 64'd1024 : 64'(x);
        for (int i = 1; i < n; i++) begin
            a = (a * 64'(x)) / 1024;
            if (a >= 64'd1048576) ovf = 1;
            a = a % 64'd1048576;
        end
`ifdef FIXED_POWER_SAT_EN
        if (ovf) a = 64'hFFFFF;
`endif
        return 20'(a);
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    // caller is #1 after a posedge; the request is sampled at the next edge
    task automatic issue(input logic [19:0] x, input logic [2:0] n, input logic [19:0] e, input bit push);
        bus.in_valid  = 1'b1;
        bus.in_data_1 = x;
        bus.in_data_2 = n;
        if (push) sb.push_back('{data: e, cyc: cyc + 1 + ((n == 0) ? 1 : int'(n))});
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_data_1 = 20'($urandom);
        bus.in_data_2 = 3'($urandom);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.out_valid) seen = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL timeout: out_valid never seen within 20 cycles");
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (bus.out_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected out_valid: data %05h at cycle %0d", bus.out_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.out_data !== e.data) begin
                    fails++;
                    $display("FAIL result: got %05h expected %05h", bus.out_data, e.data);
                end
                tests++;
                if (cyc != e.cyc) begin
                    fails++;
                    $display("FAIL latency: out_valid at cycle %0d expected %0d", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data_1 = '0;
        bus.in_data_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 20'(bus.out_valid), 20'h0);
        check("reset out_data", bus.out_data, 20'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(20'h00800, 3'd3, 20'h02000, 1); wait_done();
        issue(20'h00600, 3'd2, 20'h00900, 1); wait_done();
        issue(20'h00001, 3'd2, 20'h00000, 1); wait_done();
        issue(20'h12345, 3'd1, 20'h12345, 1); wait_done();
        issue(20'h00000, 3'd0, 20'h00400, 1); wait_done();
`ifdef FIXED_POWER_SAT_EN
        issue(20'h0A000, 3'd2, 20'hFFFFF, 1); wait_done();
`else
        issue(20'h0A000, 3'd2, 20'h90000, 1); wait_done();
`endif

        // second request during MULT is dropped; the one issued in the out_valid cycle is taken
        issue(20'h00800, 3'd7, 20'h20000, 1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        issue(20'h00C00, 3'd2, 20'h0, 0);
        wait_done();
        issue(20'h00600, 3'd2, 20'h00900, 1); wait_done();

        // reset at E2 aborts the in-flight request
        @(posedge clk);
        #1;
        issue(20'h00800, 3'd5, 20'h0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort out_valid", 20'(bus.out_valid), 20'h0);
        check("abort out_data", bus.out_data, 20'h0);
        repeat (8) @(posedge clk);
        #1;
        issue(20'h00800, 3'd5, 20'h08000, 1); wait_done();

        for (int k = 0; k < 60; k++) begin
            logic [19:0] x;
            logic [2:0]  n;
            x = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(0, 20'hFFFFF)) : 20'($urandom_range(0, 12'hFFF));
            n = 3'($urandom_range(0, 7));
            issue(x, n, pow_ref(x, int'(n)), 1);
            wait_done();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
